// File: rtl/button_debouncer.sv
// Push-button conditioning stage. Each channel is synchronised with two flops,
// debounced with a stable-time counter and turned into a clean level, one-cycle
// press/release pulses, a press-toggled state and a wrapping 8-bit press count.
module button_debouncer #(
   parameter int NUM_BUTTONS   = 2,
   parameter int STABLE_CYCLES = 1000000,
   parameter int CNT_WIDTH     = 20,
   parameter int ACTIVE_LOW    = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_BUTTONS-1:0]     btn_in,
   output logic [NUM_BUTTONS-1:0]     btn_level,
   output logic [NUM_BUTTONS-1:0]     btn_press,
   output logic [NUM_BUTTONS-1:0]     btn_release,
   output logic [NUM_BUTTONS-1:0]     btn_toggle,
   output logic [8*NUM_BUTTONS-1:0]   press_count
);

   // Elaboration-time guard: the counter must reach STABLE_CYCLES-1 and the
   // qualify window must be at least two cycles long.
   if (STABLE_CYCLES < 2 || (CNT_WIDTH < 31 && (2**CNT_WIDTH) <= STABLE_CYCLES)) begin : g_param_check
      $error("button_debouncer: STABLE_CYCLES must be >= 2 and 2**CNT_WIDTH > STABLE_CYCLES");
   end

   // Last count value before the level is allowed to follow the input.
   localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
   // Pin polarity: a pressed button always reads as 1 after this inversion.
   localparam logic LP_INV = (ACTIVE_LOW != 0);

   // Per-cycle decision of the debounce FSM.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_QUALIFY,
      ST_COMMIT
   } step_t;

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
      logic                 r_s1;
      logic                 r_s2;
      logic [CNT_WIDTH-1:0] r_cnt;
      logic                 r_level;
      logic                 r_press;
      logic                 r_release;
      logic                 r_toggle;
      logic [7:0]           r_count;
      step_t                w_step;

      // Two-flop synchroniser for the asynchronous pin, polarity-corrected first.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
         end else begin
            r_s1 <= btn_in[g] ^ LP_INV;
            r_s2 <= r_s1;
         end
      end

      // Classify the cycle: input agrees with level, still qualifying, or stable long enough.
      always_comb begin
         w_step = ST_IDLE;
         if (r_s2 != r_level) begin
            if (r_cnt == LP_LAST) begin
               w_step = ST_COMMIT;
            end else begin
               w_step = ST_QUALIFY;
            end
         end
      end

      // Debounce FSM with registered level, edge pulses, toggle and press counter.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_toggle  <= 1'b0;
            r_count   <= 8'd0;
         end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (w_step)
               ST_QUALIFY: begin
                  r_cnt <= r_cnt + 1'b1;
               end
               ST_COMMIT: begin
                  r_cnt   <= '0;
                  r_level <= r_s2;
                  if (r_s2) begin
                     r_press  <= 1'b1;
                     r_toggle <= ~r_toggle;
                     r_count  <= r_count + 8'd1;
                  end else begin
                     r_release <= 1'b1;
                  end
               end
               default: begin
                  // A bounce back to the current level restarts qualification.
                  r_cnt <= '0;
               end
            endcase
         end
      end

      assign btn_level[g]          = r_level;
      assign btn_press[g]          = r_press;
      assign btn_release[g]        = r_release;
      assign btn_toggle[g]         = r_toggle;
      assign press_count[8*g +: 8] = r_count;
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=16: clean press,
// bounce rejection, release/toggle, counter wrap, mid-qualify reset and
// active-low pin polarity (second instance).
module tb_button_debouncer;

   localparam int NB  = 2;
   localparam int SC  = 16;
   localparam int CW  = 5;
   localparam int LAT = SC + 2;   // ticks from driving the pin to the pulse

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn_in;
   logic [NB-1:0] btn_level, btn_press, btn_release, btn_toggle;
   logic [8*NB-1:0] press_count;

   logic          rst_al;
   logic [NB-1:0] btn_in_al;
   logic [NB-1:0] lvl_al, prs_al, rel_al, tgl_al;
   logic [8*NB-1:0] cnt_al;

   int n_checks = 0;
   int n_errors = 0;

   int p0 = 0, p1 = 0, r0 = 0, r1 = 0, both0 = 0, pal = 0, ral = 0;

   always #5 clk = ~clk;

   button_debouncer #(.NUM_BUTTONS(NB), .STABLE_CYCLES(SC), .CNT_WIDTH(CW), .ACTIVE_LOW(0)) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level), .btn_press(btn_press),
      .btn_release(btn_release), .btn_toggle(btn_toggle), .press_count(press_count)
   );

   button_debouncer #(.NUM_BUTTONS(NB), .STABLE_CYCLES(SC), .CNT_WIDTH(CW), .ACTIVE_LOW(1)) dut_al (
      .clk(clk), .rst(rst_al), .btn_in(btn_in_al), .btn_level(lvl_al), .btn_press(prs_al),
      .btn_release(rel_al), .btn_toggle(tgl_al), .press_count(cnt_al)
   );

   // Pulse counters, sampled on the falling edge so each one-cycle pulse is seen once.
   always @(negedge clk) begin
      if (btn_press[0])   p0++;
      if (btn_press[1])   p1++;
      if (btn_release[0]) r0++;
      if (btn_release[1]) r1++;
      if (btn_press[0] && btn_release[0]) both0++;
      pal += int'(prs_al[0]) + int'(prs_al[1]);
      ral += int'(rel_al[0]) + int'(rel_al[1]);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ticks until the selected press pulse is seen; 60 means it never came.
   task automatic wait_press(input int ch, input bit al, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(al ? prs_al[ch] : btn_press[ch]) && n < 60);
   endtask

   task automatic wait_release(input int ch, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!btn_release[ch] && n < 60);
   endtask

   initial begin
      int n, sp0, sr0, sp1;
      rst = 1'b1; btn_in = '0;
      rst_al = 1'b1; btn_in_al = 2'b11;
      repeat (3) tick();
      rst = 1'b0; rst_al = 1'b0;
      tick();

      // Reset state
      check("rst_level", 32'(btn_level), 0);
      check("rst_pulses", 32'({btn_press, btn_release}), 0);
      check("rst_toggle", 32'(btn_toggle), 0);
      check("rst_count", 32'(press_count), 0);

      // 1. Clean press on channel 0
      repeat (5) tick();
      btn_in[0] = 1'b1;
      wait_press(0, 1'b0, n);
      check("t1_latency", n, LAT);
      check("t1_level", 32'(btn_level[0]), 1);
      check("t1_count", 32'(press_count[7:0]), 1);
      check("t1_toggle", 32'(btn_toggle[0]), 1);
      check("t1_ch1_quiet", 32'({btn_level[1], btn_toggle[1], press_count[15:8]}), 0);
      tick();
      check("t1_pulse_width", 32'(btn_press[0]), 0);
      check("t1_level_hold", 32'(btn_level[0]), 1);

      // 2. Release, then bounce, then a clean hold
      btn_in[0] = 1'b0;
      wait_release(0, n);
      check("t2_release_latency", n, LAT);
      check("t2_level_low", 32'(btn_level[0]), 0);
      repeat (5) tick();
      sp0 = p0;
      for (int i = 0; i < 60; i++) begin
         if (i % 5 == 0) btn_in[0] = ~btn_in[0];
         tick();
      end
      check("t2_no_press_bounce", p0 - sp0, 0);
      check("t2_level_bounce", 32'(btn_level[0]), 0);
      btn_in[0] = 1'b1;
      wait_press(0, 1'b0, n);
      check("t2_hold_latency", n, LAT);
      tick();
      check("t2_single_press", p0 - sp0, 1);

      // 3. Press, release, press with 40-cycle holds from a fresh reset
      btn_in[0] = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      sp0 = p0; sr0 = r0;
      btn_in[0] = 1'b1; repeat (40) tick();
      btn_in[0] = 1'b0; repeat (40) tick();
      btn_in[0] = 1'b1; repeat (40) tick();
      check("t3_presses", p0 - sp0, 2);
      check("t3_releases", r0 - sr0, 1);
      check("t3_toggle", 32'(btn_toggle[0]), 0);
      check("t3_count", 32'(press_count[7:0]), 2);
      check("t3_level", 32'(btn_level[0]), 1);
      check("t3_no_overlap", both0, 0);

      // 4. 256 presses on channel 1
      sp1 = p1;
      for (int i = 1; i <= 256; i++) begin
         btn_in[1] = 1'b1; repeat (20) tick();
         if (i == 1)   check("t4_count_1", 32'(press_count[15:8]), 1);
         if (i == 255) check("t4_count_255", 32'(press_count[15:8]), 255);
         if (i == 256) check("t4_count_wrap", 32'(press_count[15:8]), 0);
         btn_in[1] = 1'b0; repeat (20) tick();
      end
      check("t4_presses", p1 - sp1, 256);
      check("t4_releases", r1, 256);
      check("t4_toggle", 32'(btn_toggle[1]), 0);
      check("t4_ch0_count", 32'(press_count[7:0]), 2);

      // 5. Reset while channel 0 is qualifying (cnt = 10)
      btn_in[0] = 1'b0;
      repeat (40) tick();
      btn_in[0] = 1'b1;
      repeat (12) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_level", 32'(btn_level), 0);
      check("t5_pulses", 32'({btn_press, btn_release}), 0);
      check("t5_toggle", 32'(btn_toggle), 0);
      check("t5_count", 32'(press_count), 0);
      wait_press(0, 1'b0, n);
      check("t5_latency", n, LAT);
      check("t5_count_after", 32'(press_count[7:0]), 1);

      // 6. Active-low instance: held high pins mean released
      check("t6_no_pulses", pal + ral, 0);
      check("t6_level_idle", 32'(lvl_al), 0);
      btn_in_al[1] = 1'b0;
      wait_press(1, 1'b1, n);
      check("t6_latency", n, LAT);
      check("t6_level", 32'(lvl_al), 32'd2);
      check("t6_count", 32'(cnt_al[15:8]), 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for the board's push-button inputs (button_a, button_b).
- Synchronises each raw pin into the clk domain, debounces it with a stable-time counter, and produces clean outputs: a debounced level, one-cycle press and release pulses, a press-toggled state, and a wrapping press count.
- The top level consumes btn_level or btn_toggle in place of the raw pins, for example to drive led_external.

Parameters:
- NUM_BUTTONS, 2, number of independent channels.
- STABLE_CYCLES, 1000000, cycles the synchronised input must differ from btn_level before btn_level updates (20 ms at 50 MHz). Must be >= 2.
- CNT_WIDTH, 20, width of each per-channel debounce counter. Must satisfy 2^CNT_WIDTH > STABLE_CYCLES.
- ACTIVE_LOW, 0, when 1 each raw input is inverted before synchronisation, so a pressed button always reads as 1 internally.

Ports:
- clk, input, 1, 50 MHz system clock.
- rst, input, 1, synchronous active-high reset.
- btn_in, input, NUM_BUTTONS, raw asynchronous button pins.
- btn_level, output, NUM_BUTTONS, debounced level (1 = pressed).
- btn_press, output, NUM_BUTTONS, one-cycle pulse when btn_level rises.
- btn_release, output, NUM_BUTTONS, one-cycle pulse when btn_level falls.
- btn_toggle, output, NUM_BUTTONS, inverts on every press.
- press_count, output, 8*NUM_BUTTONS, per-channel 8-bit press counter. Channel i occupies bits [8i+7:8i].

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst. All state is registered on the rising edge of clk.
- Reset (rst=1 at a clk edge) sets to 0: both sync flops, the debounce counter, btn_level, btn_press, btn_release, btn_toggle and press_count, for every channel. rst has priority over all other activity.
- Synchroniser: 2-flop chain per channel, s1 <= btn_in ^ ACTIVE_LOW, then s2 <= s1. Every later stage looks only at s2.
- Debounce FSM, per channel. State is btn_level plus cnt.
  - IDLE (s2 == btn_level): cnt <= 0.
  - QUALIFY (s2 != btn_level, cnt < STABLE_CYCLES-1): cnt <= cnt+1.
  - COMMIT (s2 != btn_level, cnt == STABLE_CYCLES-1): btn_level <= s2, cnt <= 0.
- Glitch rejection: any return of s2 to btn_level before COMMIT clears cnt. A bounce therefore restarts qualification from zero.
- Latency: btn_level updates STABLE_CYCLES edges after the first edge at which s2 differs from btn_level. From the pin this is STABLE_CYCLES+2 edges, with ±1 edge of synchroniser sampling uncertainty.
- btn_press is asserted for exactly one cycle, registered on the same edge that btn_level goes 0->1. btn_release is the same for 1->0. The two can never be high together on one channel.
- btn_toggle <= ~btn_toggle on the press edge only. Release does not affect it.
- press_count increments by 1 on the press edge and wraps 255 -> 0 with no saturation and no flag.
- Channels are fully independent. Simultaneous presses on several channels each produce their own pulse in the same cycle.
- Reset mid-qualification discards the partial count.
- A button held through reset re-qualifies from level 0 after reset deasserts. It then produces a press pulse STABLE_CYCLES+2 cycles later, and press_count becomes 1.
- If the input is held constant, outputs stay static indefinitely. The counter never runs while s2 == btn_level.
- Parameter violations (STABLE_CYCLES < 2, or counter too narrow) are caught by a synthesis-time check that triggers an elaboration error.

Test Plan:
1. Clean press, NUM_BUTTONS=2, STABLE_CYCLES=16: hold btn_in[0]=1 from cycle 10. Required: btn_level[0] rises at cycle 28 (±1), btn_press[0] is high for that single cycle, press_count[7:0]=1, btn_toggle[0]=1, and channel 1 outputs stay 0.
2. Bounce rejection: toggle btn_in[0] every 5 cycles for 60 cycles, then hold it at 1. Required: no press pulse during the bouncing; exactly one press pulse 18 (±1) cycles after the final hold begins.
3. Release and toggle: press, release, press again with 40-cycle holds. Required: btn_release pulses once per release, btn_toggle ends at 0, press_count=2.
4. Wrap: generate 256 qualified presses on channel 1. Required: press_count[15:8] reads 255 after press 255 and 0 after press 256, and btn_toggle[1]=0.
5. Reset mid-operation: assert rst for 1 cycle when cnt=10 with the button still held. Required: all outputs read 0 the cycle after reset, and a press pulse occurs 18 (±1) cycles after rst deasserts.
6. ACTIVE_LOW=1: hold btn_in=2'b11 from reset. Required: no pulses. Then drive btn_in[1]=0, and btn_press[1] must fire 18 (±1) cycles later.
